// File: rtl/t5_csrx.sv
// t5_csrx: hart-banked machine-mode CSR and trap unit for the tra5 barrel core.
// Each hart owns mscratch/mepc/mcause/mtval/mtvec and a minstret counter;
// mcycle is shared. CSR reads and redirect targets are registered (latency 1).
module t5_csrx #(
    parameter int              XLEN  = 32,
    parameter int              HARTS = 4,
    parameter int              HW    = 2,
    parameter logic [XLEN-1:0] RVEC  = 32'h0
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            sena,
    input  logic [HW-1:0]   dhart,
    input  logic            dcsr,
    input  logic [2:0]      dfn3,
    input  logic [11:0]     dadr,
    input  logic [4:0]      dzim,
    input  logic [XLEN-1:0] dop1,
    input  logic            dret,
    input  logic            xtrp,
    input  logic [HW-1:0]   xhrt,
    input  logic [3:0]      xcau,
    input  logic [XLEN-3:0] xepc,
    input  logic [XLEN-1:0] xval,
    input  logic            xrtr,
    output logic [XLEN-1:0] xcsr,
    output logic            xill,
    output logic            xjmp,
    output logic [XLEN-3:0] xtgt
);

    localparam logic [XLEN-1:0] MISA = 32'h40000100;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTR   = 12'hB02;
    localparam logic [11:0] A_MINSTRH  = 12'hB82;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;
    localparam logic [11:0] A_INSTR    = 12'hC02;
    localparam logic [11:0] A_INSTRH   = 12'hC82;

    // Per-hart banks; mepc keeps only [31:2] since the low bits always read 0.
    logic [XLEN-1:0] mscratch [HARTS];
    logic [XLEN-3:0] mepc     [HARTS];
    logic [3:0]      mcause   [HARTS];
    logic [XLEN-1:0] mtval    [HARTS];
    logic [XLEN-1:0] mtvec    [HARTS];
    logic [63:0]     minstret [HARTS];
    logic [63:0]     mcycle;

    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] wdata;
    logic            mapped;
    logic            ro;
    logic            wreq;
    logic            ill;
    logic            wen;

    // Decode the CSR access: old value, legality and the value to write back.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        mask   = dfn3[2] ? {{(XLEN-5){1'b0}}, dzim} : dop1;
        rdata  = '0;
        mapped = 1'b1;
        ro     = 1'b0;
        case (dadr)
            A_MSTATUS:  rdata = '0;
            A_MISA:     begin rdata = MISA; ro = 1'b1; end
            A_MTVEC:    rdata = mtvec[dhart];
            A_MSCRATCH: rdata = mscratch[dhart];
            A_MEPC:     rdata = {mepc[dhart], 2'b00};
            A_MCAUSE:   rdata = {{(XLEN-4){1'b0}}, mcause[dhart]};
            A_MTVAL:    rdata = mtval[dhart];
            A_MHARTID:  begin rdata = {{(XLEN-HW){1'b0}}, dhart}; ro = 1'b1; end
            A_MCYCLE:   rdata = mcycle[31:0];
            A_MCYCLEH:  rdata = mcycle[63:32];
            A_MINSTR:   rdata = minstret[dhart][31:0];
            A_MINSTRH:  rdata = minstret[dhart][63:32];
            A_CYCLE:    begin rdata = mcycle[31:0];           ro = 1'b1; end
            A_CYCLEH:   begin rdata = mcycle[63:32];          ro = 1'b1; end
            A_INSTR:    begin rdata = minstret[dhart][31:0];  ro = 1'b1; end
            A_INSTRH:   begin rdata = minstret[dhart][63:32]; ro = 1'b1; end
            default:    mapped = 1'b0;
        endcase

        // RS/RC with an all-zero mask is a pure read.
        wreq = (dfn3[1:0] == 2'b01) || ((dfn3[1:0] != 2'b00) && (mask != '0));
        ill  = dcsr && (!mapped || (wreq && ro));
        wen  = dcsr && wreq && !ill;

        case (dfn3[1:0])
            2'b01:   wdata = mask;
            2'b10:   wdata = rdata | mask;
            2'b11:   wdata = rdata & ~mask;
            default: wdata = rdata;
        endcase
    end

    // State update: counting, CSR writes, trap capture, registered outputs.
    // Later assignments in this block override earlier ones, which encodes
    // the priorities: CSR write beats increment, trap capture beats CSR write.
    always_ff @(posedge sclk) begin
        if (srst) begin
            // NOTE: the banks are small flop arrays, not RAM, so they are reset explicitly.
            for (int h = 0; h < HARTS; h++) begin
                mscratch[h] <= '0;
                mepc[h]     <= '0;
                mcause[h]   <= '0;
                mtval[h]    <= '0;
                mtvec[h]    <= RVEC;
                minstret[h] <= '0;
            end
            mcycle <= '0;
            xcsr   <= '0;
            xill   <= 1'b0;
            xjmp   <= 1'b0;
            xtgt   <= '0;
        end else if (sena) begin
            // NOTE: state uses non-blocking assignments so every read sees the pre-edge value.
            mcycle <= mcycle + 64'd1;
            for (int h = 0; h < HARTS; h++) begin
                if (xrtr && (xhrt == HW'(h))) begin
                    minstret[h] <= minstret[h] + 64'd1;
                end
            end

            if (wen) begin
                case (dadr)
                    A_MTVEC:    mtvec[dhart]    <= wdata;
                    A_MSCRATCH: mscratch[dhart] <= wdata;
                    A_MEPC:     mepc[dhart]     <= wdata[XLEN-1:2];
                    A_MCAUSE:   mcause[dhart]   <= wdata[3:0];
                    A_MTVAL:    mtval[dhart]    <= wdata;
                    A_MCYCLE:   mcycle          <= {mcycle[63:32], wdata};
                    A_MCYCLEH:  mcycle          <= {wdata, mcycle[31:0]};
                    A_MINSTR:   minstret[dhart] <= {minstret[dhart][63:32], wdata};
                    A_MINSTRH:  minstret[dhart] <= {wdata, minstret[dhart][31:0]};
                    default:    ;
                endcase
            end

            if (xtrp) begin
                mepc[xhrt]   <= xepc;
                mcause[xhrt] <= xcau;
                mtval[xhrt]  <= xval;
            end

            xcsr <= (dcsr && !ill) ? rdata : '0;
            xill <= ill;
            xjmp <= xtrp || dret;
            if (xtrp) begin
                xtgt <= mtvec[xhrt][XLEN-1:2];
            end else if (dret) begin
                xtgt <= mepc[dhart];
            end
        end
    end

endmodule

// File: tb/tb_t5_csrx.sv
// Self-checking bench for t5_csrx: directed scenarios plus a randomized run
// against a behavioural model of the CSR file kept as plain per-hart values.
module tb_t5_csrx;

    localparam int          XLEN  = 32;
    localparam int          HARTS = 4;
    localparam int          HW    = 2;
    localparam logic [31:0] RVEC  = 32'h0;

    logic        sclk = 1'b0;
    logic        srst, sena;
    logic [1:0]  dhart;
    logic        dcsr;
    logic [2:0]  dfn3;
    logic [11:0] dadr;
    logic [4:0]  dzim;
    logic [31:0] dop1;
    logic        dret, xtrp;
    logic [1:0]  xhrt;
    logic [3:0]  xcau;
    logic [29:0] xepc;
    logic [31:0] xval;
    logic        xrtr;
    logic [31:0] xcsr;
    logic        xill, xjmp;
    logic [29:0] xtgt;

    int checks = 0;
    int errors = 0;

    t5_csrx #(.XLEN(XLEN), .HARTS(HARTS), .HW(HW), .RVEC(RVEC)) dut (
        .sclk(sclk), .srst(srst), .sena(sena),
        .dhart(dhart), .dcsr(dcsr), .dfn3(dfn3), .dadr(dadr), .dzim(dzim), .dop1(dop1),
        .dret(dret), .xtrp(xtrp), .xhrt(xhrt), .xcau(xcau), .xepc(xepc), .xval(xval),
        .xrtr(xrtr), .xcsr(xcsr), .xill(xill), .xjmp(xjmp), .xtgt(xtgt)
    );

    always #5 sclk = ~sclk;

    // Reference model: architectural values per hart, full 32-bit storage.
    logic [31:0]     m_scr [4];
    logic [31:0]     m_epc [4];
    logic [31:0]     m_cau [4];
    logic [31:0]     m_val [4];
    logic [31:0]     m_tvec[4];
    longint unsigned m_ins [4];
    longint unsigned m_cyc;
    logic [31:0]     e_csr;
    logic            e_ill, e_jmp;
    logic [29:0]     e_tgt;

    logic [11:0] adr_list [18] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'h343, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                   12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0, 12'h123};

    task automatic model_read(input int h, input logic [11:0] a,
                              output bit ok, output bit ro, output logic [31:0] v);
        ok = 1'b1; ro = 1'b0; v = 32'h0;
        case (a)
            12'h300: v = 32'h0;
            12'h301: begin v = 32'h40000100; ro = 1'b1; end
            12'h305: v = m_tvec[h];
            12'h340: v = m_scr[h];
            12'h341: v = m_epc[h] & 32'hFFFF_FFFC;
            12'h342: v = m_cau[h] & 32'h0000_000F;
            12'h343: v = m_val[h];
            12'hF14: begin v = 32'(h); ro = 1'b1; end
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB02: v = m_ins[h][31:0];
            12'hB82: v = m_ins[h][63:32];
            12'hC00: begin v = m_cyc[31:0];     ro = 1'b1; end
            12'hC80: begin v = m_cyc[63:32];    ro = 1'b1; end
            12'hC02: begin v = m_ins[h][31:0];  ro = 1'b1; end
            12'hC82: begin v = m_ins[h][63:32]; ro = 1'b1; end
            default: ok = 1'b0;
        endcase
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_eval();
        bit              ok, ro, wr, ill;
        logic [31:0]     old, mask, w;
        longint unsigned ncyc;
        longint unsigned nins[4];
        int              dh, xh;
        dh = int'(dhart);
        xh = int'(xhrt);
        if (srst) begin
            for (int h = 0; h < 4; h++) begin
                m_scr[h] = 0; m_epc[h] = 0; m_cau[h] = 0; m_val[h] = 0;
                m_tvec[h] = RVEC; m_ins[h] = 0;
            end
            m_cyc = 0; e_csr = 0; e_ill = 0; e_jmp = 0; e_tgt = 0;
            return;
        end
        if (!sena) return;
        ncyc = m_cyc + 1;
        for (int h = 0; h < 4; h++) nins[h] = m_ins[h] + ((xrtr && xh == h) ? 1 : 0);
        e_jmp = xtrp || dret;
        if (xtrp)      e_tgt = m_tvec[xh][31:2];
        else if (dret) e_tgt = m_epc[dh][31:2];
        e_csr = 0;
        e_ill = 0;
        if (dcsr) begin
            model_read(dh, dadr, ok, ro, old);
            mask  = dfn3[2] ? {27'd0, dzim} : dop1;
            wr    = (dfn3[1:0] == 2'd1) || (dfn3[1:0] != 2'd0 && mask != 0);
            ill   = !ok || (wr && ro);
            e_ill = ill;
            e_csr = ill ? 32'h0 : old;
            if (!ill && wr) begin
                case (dfn3[1:0])
                    2'd1:    w = mask;
                    2'd2:    w = old | mask;
                    default: w = old & ~mask;
                endcase
                case (dadr)
                    12'h305: m_tvec[dh] = w;
                    12'h340: m_scr[dh]  = w;
                    12'h341: m_epc[dh]  = w;
                    12'h342: m_cau[dh]  = w;
                    12'h343: m_val[dh]  = w;
                    12'hB00: ncyc     = {m_cyc[63:32], w};
                    12'hB80: ncyc     = {w, m_cyc[31:0]};
                    12'hB02: nins[dh] = {m_ins[dh][63:32], w};
                    12'hB82: nins[dh] = {w, m_ins[dh][31:0]};
                    default: ;
                endcase
            end
        end
        if (xtrp) begin
            m_epc[xh] = {xepc, 2'b00};
            m_cau[xh] = {28'd0, xcau};
            m_val[xh] = xval;
        end
        m_cyc = ncyc;
        for (int h = 0; h < 4; h++) m_ins[h] = nins[h];
    endtask

    // One clock: update model, take the edge, sample #1 later, drop pulses.
    task automatic step();
        model_eval();
        @(posedge sclk);
        #1;
        dcsr = 0; dret = 0; xtrp = 0; xrtr = 0;
    endtask

    task automatic csr_op(input logic [1:0] h, input logic [2:0] fn, input logic [11:0] a,
                          input logic [4:0] z, input logic [31:0] op);
        dcsr = 1; dhart = h; dfn3 = fn; dadr = a; dzim = z; dop1 = op;
        step();
    endtask

    task automatic test_reset();
        srst = 1; sena = 0;
        step();
        sena = 1;
        step();
        srst = 0;
        checks++; if (xcsr !== 32'h0) begin errors++; $display("FAIL reset_xcsr got %h exp %h", xcsr, 32'h0); end
        checks++; if (xill !== 1'b0)  begin errors++; $display("FAIL reset_xill got %b exp 0", xill); end
        checks++; if (xjmp !== 1'b0)  begin errors++; $display("FAIL reset_xjmp got %b exp 0", xjmp); end
        checks++; if (xtgt !== 30'h0) begin errors++; $display("FAIL reset_xtgt got %h exp 0", xtgt); end
        for (int h = 0; h < 4; h++) begin
            csr_op(2'(h), 3'b010, 12'h305, 5'd0, 32'h0);
            checks++; if (xcsr !== RVEC || xill !== 1'b0) begin
                errors++; $display("FAIL reset_mtvec h%0d got %h/%b exp %h/0", h, xcsr, xill, RVEC);
            end
        end
        csr_op(2'd2, 3'b010, 12'hF14, 5'd0, 32'h0);
        checks++; if (xcsr !== 32'd2) begin errors++; $display("FAIL mhartid got %h exp 2", xcsr); end
    endtask

    task automatic test_scratch();
        csr_op(2'd1, 3'b001, 12'h340, 5'd0, 32'hDEADBEEF);
        csr_op(2'd0, 3'b010, 12'h340, 5'd0, 32'h0);
        checks++; if (xcsr !== 32'h0) begin errors++; $display("FAIL scratch_h0 got %h exp 0", xcsr); end
        csr_op(2'd1, 3'b010, 12'h340, 5'd0, 32'h0);
        checks++; if (xcsr !== 32'hDEADBEEF) begin errors++; $display("FAIL scratch_h1 got %h exp deadbeef", xcsr); end
        csr_op(2'd1, 3'b111, 12'h340, 5'h0F, 32'h0);
        checks++; if (xcsr !== 32'hDEADBEEF) begin errors++; $display("FAIL scratch_rci got %h exp deadbeef", xcsr); end
        csr_op(2'd1, 3'b010, 12'h340, 5'd0, 32'h0);
        checks++; if (xcsr !== 32'hDEADBEE0) begin errors++; $display("FAIL scratch_after got %h exp deadbee0", xcsr); end
    endtask

    task automatic test_trap();
        csr_op(2'd3, 3'b001, 12'h305, 5'd0, 32'h100);
        xtrp = 1; xhrt = 2'd3; xcau = 4'd4; xepc = 30'h40; xval = 32'h123;
        step();
        checks++; if (xjmp !== 1'b1 || xtgt !== 30'h40) begin
            errors++; $display("FAIL trap_redirect got %b/%h exp 1/40", xjmp, xtgt);
        end
        step();
        checks++; if (xjmp !== 1'b0) begin errors++; $display("FAIL trap_pulse got %b exp 0", xjmp); end
        csr_op(2'd3, 3'b010, 12'h341, 5'd0, 32'h0);
        checks++; if (xcsr !== 32'h100) begin errors++; $display("FAIL trap_mepc got %h exp 100", xcsr); end
        csr_op(2'd3, 3'b010, 12'h342, 5'd0, 32'h0);
        checks++; if (xcsr !== 32'h4) begin errors++; $display("FAIL trap_mcause got %h exp 4", xcsr); end
        csr_op(2'd3, 3'b010, 12'h343, 5'd0, 32'h0);
        checks++; if (xcsr !== 32'h123) begin errors++; $display("FAIL trap_mtval got %h exp 123", xcsr); end
        dret = 1; dhart = 2'd3;
        step();
        checks++; if (xjmp !== 1'b1 || xtgt !== 30'h40) begin
            errors++; $display("FAIL mret_redirect got %b/%h exp 1/40", xjmp, xtgt);
        end
    endtask

    task automatic test_collision();
        csr_op(2'd0, 3'b001, 12'h305, 5'd0, 32'h200);
        xtrp = 1; xhrt = 2'd0; xcau = 4'd2; xepc = 30'h11; xval = 32'h55;
        csr_op(2'd0, 3'b001, 12'h341, 5'd0, 32'h888);
        checks++; if (xjmp !== 1'b1 || xtgt !== 30'h80) begin
            errors++; $display("FAIL coll_redirect got %b/%h exp 1/80", xjmp, xtgt);
        end
        csr_op(2'd0, 3'b010, 12'h341, 5'd0, 32'h0);
        checks++; if (xcsr !== 32'h44) begin errors++; $display("FAIL coll_mepc got %h exp 44", xcsr); end
        xtrp = 1; xhrt = 2'd0; xepc = 30'h22; dret = 1; dhart = 2'd0;
        step();
        checks++; if (xjmp !== 1'b1 || xtgt !== 30'h80) begin
            errors++; $display("FAIL trap_over_mret got %b/%h exp 1/80", xjmp, xtgt);
        end
    endtask

    task automatic test_counter();
        logic [31:0] v1;
        csr_op(2'd0, 3'b001, 12'hB00, 5'd0, 32'hFFFFFFFF);
        step();
        csr_op(2'd0, 3'b010, 12'hB80, 5'd0, 32'h0);
        checks++; if (xcsr !== 32'h1) begin errors++; $display("FAIL mcycle_carry got %h exp 1", xcsr); end
        csr_op(2'd0, 3'b010, 12'hC00, 5'd0, 32'h0);
        v1 = xcsr;
        sena = 0;
        for (int i = 0; i < 5; i++) begin
            dcsr = 1; dhart = 2'd0; dfn3 = 3'b010; dadr = 12'hB00; xrtr = 1; xhrt = 2'd1;
            step();
            checks++; if (xcsr !== v1) begin errors++; $display("FAIL sena_hold got %h exp %h", xcsr, v1); end
        end
        sena = 1;
        csr_op(2'd0, 3'b010, 12'hB00, 5'd0, 32'h0);
        checks++; if (xcsr !== v1 + 32'd1) begin errors++; $display("FAIL sena_count got %h exp %h", xcsr, v1 + 32'd1); end
    endtask

    task automatic test_minstret();
        logic [31:0] a;
        csr_op(2'd2, 3'b010, 12'hB02, 5'd0, 32'h0);
        a = xcsr;
        for (int i = 0; i < 3; i++) begin
            xrtr = 1; xhrt = 2'd2;
            step();
        end
        csr_op(2'd2, 3'b010, 12'hB02, 5'd0, 32'h0);
        checks++; if (xcsr !== a + 32'd3) begin errors++; $display("FAIL minstret_count got %h exp %h", xcsr, a + 32'd3); end
        xrtr = 1; xhrt = 2'd2;
        csr_op(2'd2, 3'b001, 12'hB02, 5'd0, 32'h50);
        csr_op(2'd2, 3'b010, 12'hB02, 5'd0, 32'h0);
        checks++; if (xcsr !== 32'h50) begin errors++; $display("FAIL minstret_wr_wins got %h exp 50", xcsr); end
    endtask

    task automatic test_illegal();
        csr_op(2'd0, 3'b001, 12'h301, 5'd0, 32'h12345678);
        checks++; if (xill !== 1'b1 || xcsr !== 32'h0) begin
            errors++; $display("FAIL misa_write got %b/%h exp 1/0", xill, xcsr);
        end
        csr_op(2'd0, 3'b010, 12'h301, 5'd0, 32'h0);
        checks++; if (xill !== 1'b0 || xcsr !== 32'h40000100) begin
            errors++; $display("FAIL misa_read got %b/%h exp 0/40000100", xill, xcsr);
        end
        csr_op(2'd0, 3'b110, 12'hC00, 5'd3, 32'h0);
        checks++; if (xill !== 1'b1) begin errors++; $display("FAIL ro_setbits got %b exp 1", xill); end
        csr_op(2'd0, 3'b010, 12'h7C0, 5'd0, 32'h0);
        checks++; if (xill !== 1'b1 || xcsr !== 32'h0) begin
            errors++; $display("FAIL unmapped got %b/%h exp 1/0", xill, xcsr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            sena  = ($urandom_range(0, 9) != 0);
            dcsr  = ($urandom_range(0, 3) != 0);
            dhart = 2'($urandom_range(0, 3));
            dfn3  = 3'($urandom_range(0, 7));
            dadr  = adr_list[$urandom_range(0, 17)];
            dzim  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            dop1  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            dret  = ($urandom_range(0, 7) == 0);
            xtrp  = ($urandom_range(0, 7) == 0);
            xhrt  = 2'($urandom_range(0, 3));
            xcau  = 4'($urandom);
            xepc  = 30'($urandom);
            xval  = 32'($urandom);
            xrtr  = ($urandom_range(0, 1) == 1);
            step();
            checks++; if (xcsr !== e_csr) begin errors++; $display("FAIL rnd_xcsr cyc %0d got %h exp %h", i, xcsr, e_csr); end
            checks++; if (xill !== e_ill) begin errors++; $display("FAIL rnd_xill cyc %0d got %b exp %b", i, xill, e_ill); end
            checks++; if (xjmp !== e_jmp) begin errors++; $display("FAIL rnd_xjmp cyc %0d got %b exp %b", i, xjmp, e_jmp); end
            checks++; if (xtgt !== e_tgt) begin errors++; $display("FAIL rnd_xtgt cyc %0d got %h exp %h", i, xtgt, e_tgt); end
        end
        sena = 1;
    endtask

    initial begin
        srst = 1; sena = 1; dhart = 0; dcsr = 0; dfn3 = 0; dadr = 0; dzim = 0; dop1 = 0;
        dret = 0; xtrp = 0; xhrt = 0; xcau = 0; xepc = 0; xval = 0; xrtr = 0;
        test_reset();
        test_scratch();
        test_trap();
        test_collision();
        test_counter();
        test_minstret();
        test_illegal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
